// File: rtl/aeolus_cpu_gen2.sv
// Aeolus gen2 accumulator CPU: two-cycle FETCH/EXEC core with an A/B operand pair,
// an accumulator, an output register and a carry flag, running from an async-read ROM.
module aeolus_cpu_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int IN_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    output logic [ADDR_WIDTH-1:0]   instrAddr,
    input  logic [ADDR_WIDTH+3:0]   instrData,
    input  logic [2*IN_WIDTH-1:0]   switches,
    output logic [DATA_WIDTH-1:0]   cpuOut,
    output logic                    outValid,
    output logic                    carry,
    output logic                    halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } stateType;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDA, OP_LDB, OP_LDO,
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_INV, OP_CLR, OP_LSH,
        OP_RSH, OP_JMP, OP_JNZ, OP_HLT
    } opcodeType;

    stateType               state;
    logic [ADDR_WIDTH+3:0]  ir;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [IN_WIDTH-1:0]    regA;
    logic [IN_WIDTH-1:0]    regB;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  regO;

    opcodeType              opcode;
    logic [ADDR_WIDTH-1:0]  operand;
    logic [DATA_WIDTH-1:0]  aExt;
    logic [DATA_WIDTH-1:0]  bExt;
    logic [DATA_WIDTH-1:0]  nextAcc;
    logic                   nextCarry;
    logic [ADDR_WIDTH-1:0]  pcPlusOne;
    logic [ADDR_WIDTH-1:0]  nextPc;

    assign opcode    = opcodeType'(ir[ADDR_WIDTH+3:ADDR_WIDTH]);
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign aExt      = DATA_WIDTH'(regA);
    assign bExt      = DATA_WIDTH'(regB);
    assign pcPlusOne = pc + ADDR_WIDTH'(1);
    assign instrAddr = pc;
    assign cpuOut    = regO;

    // ALU and next-PC decode for the instruction held in IR; only committed in EXEC.
    always_comb begin
        nextAcc   = acc;
        nextCarry = carry;
        nextPc    = pcPlusOne;
        case (opcode)
            OP_ADD: {nextCarry, nextAcc} = {1'b0, aExt} + {1'b0, bExt};
            OP_SUB: begin
                nextAcc   = aExt - bExt;
                nextCarry = (regA < regB);
            end
            OP_AND: nextAcc = aExt & bExt;
            OP_OR:  nextAcc = aExt | bExt;
            OP_XOR: nextAcc = aExt ^ bExt;
            OP_INV: nextAcc = ~acc;
            OP_CLR: nextAcc = '0;
            OP_LSH: begin
                nextAcc   = acc << 1;
                nextCarry = acc[DATA_WIDTH-1];
            end
            OP_RSH: begin
                nextAcc   = acc >> 1;
                nextCarry = acc[0];
            end
            OP_JMP: nextPc = operand;
            OP_JNZ: nextPc = (acc != '0) ? operand : pcPlusOne;
            OP_HLT: nextPc = pc;
            default: ;
        endcase
    end

    // Core sequencer: IR latches in FETCH, all architectural state commits in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            ir       <= '0;
            pc       <= '0;
            regA     <= '0;
            regB     <= '0;
            acc      <= '0;
            regO     <= '0;
            carry    <= 1'b0;
            outValid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state)
                FETCH: begin
                    if (run) begin
                        ir    <= instrData;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    acc   <= nextAcc;
                    carry <= nextCarry;
                    pc    <= nextPc;
                    if (opcode == OP_LDA) regA <= switches[2*IN_WIDTH-1:IN_WIDTH];
                    if (opcode == OP_LDB) regB <= switches[IN_WIDTH-1:0];
                    if (opcode == OP_LDO) begin
                        regO     <= acc;
                        outValid <= 1'b1;
                    end
                    if (opcode == OP_HLT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_aeolus_cpu_gen2.sv
// Self-checking bench for aeolus_cpu_gen2: instruction-level reference model compared on
// every falling edge, directed programs with literal expectations, then random programs.
module tb_aeolus_cpu_gen2;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  instrAddr;
    logic [11:0] instrData;
    logic [7:0]  switches;
    logic [7:0]  cpuOut;
    logic        outValid;
    logic        carry;
    logic        halted;

    logic [11:0] rom [0:255];

    int total = 0;
    int bad   = 0;

    // Reference model state, updated once per rising edge at instruction granularity.
    int          mPc = 0, mAcc = 0, mA = 0, mB = 0, mO = 0;
    int          mCarry = 0, mHalted = 0, mOutValid = 0, mExec = 0;
    int          lshCount = 0, jnzTaken = 0;
    int          opc, opnd, nextPc;
    logic [11:0] mIr = '0;

    aeolus_cpu_gen2 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .IN_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .instrAddr(instrAddr),
        .instrData(instrData),
        .switches(switches),
        .cpuOut(cpuOut),
        .outValid(outValid),
        .carry(carry),
        .halted(halted)
    );

    assign instrData = rom[instrAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The model executes whole instructions: the first edge takes the word, the second applies it.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mPc = 0; mAcc = 0; mA = 0; mB = 0; mO = 0;
                mCarry = 0; mHalted = 0; mOutValid = 0; mExec = 0;
                lshCount = 0; jnzTaken = 0; mIr = '0;
            end else begin
                mOutValid = 0;
                if (mHalted != 0) begin
                end else if (mExec == 0) begin
                    if (run) begin
                        mIr   = rom[mPc];
                        mExec = 1;
                    end
                end else begin
                    mExec  = 0;
                    opc    = int'(mIr[11:8]);
                    opnd   = int'(mIr[7:0]);
                    nextPc = (mPc + 1) % 256;
                    case (opc)
                        1:  mA = int'(switches[7:4]);
                        2:  mB = int'(switches[3:0]);
                        3:  begin mO = mAcc; mOutValid = 1; end
                        4:  begin mAcc = mA + mB; mCarry = (mAcc > 255) ? 1 : 0; mAcc = mAcc % 256; end
                        5:  begin mCarry = (mA < mB) ? 1 : 0; mAcc = (mA - mB + 256) % 256; end
                        6:  mAcc = mA & mB;
                        7:  mAcc = mA | mB;
                        8:  mAcc = mA ^ mB;
                        9:  mAcc = 255 - mAcc;
                        10: mAcc = 0;
                        11: begin mCarry = mAcc / 128; mAcc = (mAcc * 2) % 256; lshCount++; end
                        12: begin mCarry = mAcc % 2; mAcc = mAcc / 2; end
                        13: nextPc = opnd;
                        14: if (mAcc != 0) begin nextPc = opnd; jnzTaken++; end
                        15: begin mHalted = 1; nextPc = mPc; end
                        default: ;
                    endcase
                    mPc = nextPc;
                end
            end
        end
    end

    // Every falling edge outside reset, all outputs must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("instrAddr", int'(instrAddr), mPc);
            checkOutput("cpuOut",    int'(cpuOut),    mO);
            checkOutput("outValid",  int'(outValid),  mOutValid);
            checkOutput("carry",     int'(carry),     mCarry);
            checkOutput("halted",    int'(halted),    mHalted);
        end
    end

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #1;
            switches = 8'($urandom);
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
    endtask

    task automatic waitHalt(input string name);
        int n;
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(halted), 1);
    endtask

    logic [3:0] op;

    initial begin
        reset = 1'b0;
        run = 1'b0;
        switches = 8'h00;
        clearRom();
        #1 reset = 1'b1;
        #3 reset = 1'b0;

        // LDA, LDB, ADD, LDO with 3+5: result and one-cycle pulse eight edges after release.
        clearRom();
        rom[0] = 12'h100; rom[1] = 12'h200; rom[2] = 12'h400; rom[3] = 12'h300;
        switches = 8'h35; run = 1'b1;
        doReset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("addOut", int'(cpuOut), 8'h08);
        checkOutput("addPulse", int'(outValid), 1);
        checkOutput("addCarry", int'(carry), 0);
        @(negedge clk);
        checkOutput("addPulseEnd", int'(outValid), 0);

        // 3-5 borrows to FE with carry; INV gives 01 and leaves carry alone.
        clearRom();
        rom[0] = 12'h100; rom[1] = 12'h200; rom[2] = 12'h500; rom[3] = 12'h300;
        rom[4] = 12'h900; rom[5] = 12'h300;
        doReset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("subOut", int'(cpuOut), 8'hFE);
        checkOutput("subCarry", int'(carry), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("invOut", int'(cpuOut), 8'h01);
        checkOutput("invCarry", int'(carry), 1);

        // Shift a single 1 out through the MSB using a JNZ loop.
        clearRom();
        rom[0] = 12'h100; rom[1] = 12'h200; rom[2] = 12'h400;
        rom[3] = 12'hB00; rom[4] = 12'hE03; rom[5] = 12'h300;
        switches = 8'h10;
        doReset();
        waitHalt("loopHalt");
        checkOutput("loopLsh", lshCount, 8);
        checkOutput("loopJnz", jnzTaken, 7);
        checkOutput("loopOut", int'(cpuOut), 8'h00);
        checkOutput("loopCarry", int'(carry), 1);

        // JMP to the top of the address space and wrap back to 0.
        clearRom();
        rom[0] = 12'hDFE; rom[8'hFE] = 12'h000; rom[8'hFF] = 12'h000;
        doReset();
        checkOutput("wrap0", int'(instrAddr), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("wrapFE", int'(instrAddr), 8'hFE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("wrapFF", int'(instrAddr), 8'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("wrap00", int'(instrAddr), 8'h00);

        // Stall in FETCH for five cycles mid-program, then resume.
        clearRom();
        rom[0] = 12'h1AA; rom[1] = 12'h255; rom[2] = 12'h400; rom[3] = 12'h300;
        switches = 8'h35;
        doReset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallPc", int'(instrAddr), 2);
        end
        #1 run = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("resumeOut", int'(cpuOut), 8'h08);
        checkOutput("resumePulse", int'(outValid), 1);

        // Reset while LDO is in flight must drop it entirely.
        doReset();
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("abortOut", int'(cpuOut), 0);
        checkOutput("abortPulse", int'(outValid), 0);
        checkOutput("abortPc", int'(instrAddr), 0);

        // HLT at 05 holds for ten cycles; a reset pulse clears outputs with no clock edge.
        clearRom();
        rom[0] = 12'h100; rom[1] = 12'h200; rom[2] = 12'h500; rom[3] = 12'h300;
        rom[4] = 12'h000; rom[5] = 12'hF00; rom[6] = 12'h300;
        doReset();
        waitHalt("hltReach");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hltHalted", int'(halted), 1);
            checkOutput("hltPc", int'(instrAddr), 8'h05);
        end
        checkOutput("hltOut", int'(cpuOut), 8'hFE);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstPc", int'(instrAddr), 0);
        checkOutput("rstOut", int'(cpuOut), 0);
        checkOutput("rstCarry", int'(carry), 0);
        checkOutput("rstValid", int'(outValid), 0);
        checkOutput("rstHalted", int'(halted), 0);
        #1 reset = 1'b0;

        // Random programs, switches, stalls and occasional resets against the model.
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < 256; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
                rom[i] = {op, 8'($urandom)};
            end
            doReset();
            applyStimulus(200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aeolus_cpu_gen2.md
AEOLUS_CPU_GEN2 -- requirements
Module: aeolus_cpu_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of the ACC, O and ALU datapath.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: PC width and branch operand width.
REQ-003 The block SHALL have parameter IN_WIDTH, default 4: width of each of the A and B operand registers.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port run, input, 1 bit: execution enable; 0 stalls the core.
REQ-007 The block SHALL have port instrAddr, output, ADDR_WIDTH bits: PC value, driven to an asynchronous-read program ROM.
REQ-008 The block SHALL have port instrData, input, 4+ADDR_WIDTH bits: opcode in [ADDR_WIDTH+3:ADDR_WIDTH], operand in [ADDR_WIDTH-1:0].
REQ-009 The block SHALL have port switches, input, 2*IN_WIDTH bits: upper half is the A source, lower half is the B source.
REQ-010 The block SHALL have port cpuOut, output, DATA_WIDTH bits: the O register.
REQ-011 The block SHALL have port outValid, output, 1 bit: one-cycle pulse, high in the cycle after O is written.
REQ-012 The block SHALL have port carry, output, 1 bit: registered carry/borrow/shift-out flag.
REQ-013 The block SHALL have port halted, output, 1 bit: high while the FSM is in HALT.

Function
REQ-014 The FSM SHALL have exactly three states: FETCH, EXEC and HALT.
REQ-015 In FETCH with run=1, the block SHALL latch instrData into IR and go to EXEC; with run=0 it SHALL stay in FETCH and change no state.
REQ-016 In EXEC, the block SHALL execute IR and then go to FETCH (or to HALT for HLT), so every instruction takes 2 cycles; run is ignored in EXEC.
REQ-017 Opcode decode SHALL be: 0 NOP; 1 LDA (A<=upper half of switches); 2 LDB (B<=lower half of switches); 3 LDO (O<=ACC); 4 ADD (ACC<=A+B); 5 SUB (ACC<=A-B); 6 AND; 7 OR; 8 XOR, each on A,B; 9 INV (ACC<=~ACC); A CLR (ACC<=0); B LSH (ACC<=ACC<<1); C RSH (ACC>>1, logical); D JMP; E JNZ; F HLT.
REQ-018 A and B SHALL be zero-extended to DATA_WIDTH before any ALU operation.
REQ-019 Arithmetic SHALL be modulo 2^DATA_WIDTH.
REQ-020 ADD SHALL set carry to the carry-out of the addition.
REQ-021 SUB SHALL set carry to 1 when A<B (borrow).
REQ-022 LSH SHALL set carry to the old ACC MSB, and RSH SHALL set carry to the old ACC LSB; all other opcodes SHALL hold carry.
REQ-023 For non-branch opcodes, PC SHALL become PC+1 at the end of EXEC, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-024 JMP SHALL set PC to the operand.
REQ-025 JNZ SHALL set PC to the operand when ACC (value before this EXEC) is non-zero, and to PC+1 otherwise.
REQ-026 HLT SHALL freeze PC, ACC, A, B, O and carry, assert halted, and leave HALT only on reset.
REQ-027 LDO SHALL assert outValid for exactly one cycle, the cycle after the EXEC edge; outValid SHALL be 0 at all other times.
REQ-028 instrAddr SHALL equal PC at all times; the operand field SHALL be ignored for non-branch opcodes.

Reset
REQ-029 While reset=1, the block SHALL force PC, IR, A, B, ACC and O to 0, carry, outValid and halted to 0, and the state to FETCH, asynchronously and independent of clk or run.
REQ-030 Reset asserted mid-EXEC SHALL discard the in-flight instruction with no partial register update.
REQ-031 After reset deasserts, the first rising clk edge with run=1 SHALL fetch address 0.

Verification (DATA_WIDTH=8, ADDR_WIDTH=8, IN_WIDTH=4, run=1 unless stated)
REQ-032 The bench SHALL cover: switches=8'h35, program LDA,LDB,ADD,LDO -> cpuOut=8'h08 and outValid high for 1 cycle, 8 cycles after reset release.
REQ-033 The bench SHALL cover: switches=8'h35, program LDA,LDB,SUB -> ACC=8'hFE, carry=1; then INV -> ACC=8'h01, carry still 1.
REQ-034 The bench SHALL cover: switches=8'h10, program LDA,LDB,ADD,@3 LSH,@4 JNZ 3,LDO -> 8 LSH executions, JNZ taken 7 times, final ACC=8'h00, carry=1, cpuOut=8'h00.
REQ-035 The bench SHALL cover: program @0 JMP 8'hFE, @FE NOP, @FF NOP -> instrAddr sequence 00,FE,FF,00 (wrap).
REQ-036 The bench SHALL cover: run=0 held for 5 cycles in FETCH -> instrAddr, ACC and state unchanged, then resuming with run=1 continues correctly.
REQ-037 The bench SHALL cover: HLT at 8'h05 -> halted=1 and instrAddr=8'h05 stable for 10 cycles; then reset pulse mid-cycle -> all outputs 0 immediately, with no clk edge required.
